// File: rtl/pipe_stage_reg_pkg.sv
// Shared definitions for the generic inter-stage pipeline register.
// Holds the stall encodings, the NOP field constants and the payload field
// offsets for each stage boundary, so wrappers and the core agree on layout.
package pipe_stage_reg_pkg;

  // Stall vector encodings: one bit per stage, 1 = stage is stopped.
  localparam logic STOP    = 1'b1;
  localparam logic NO_STOP = 1'b0;
  localparam int   STALL_W_DEF = 6;

  // NOP field values used to build a bubble payload.
  localparam logic [7:0] EXE_NOP_OP   = 8'b0000_0000;
  localparam logic [2:0] EXE_RES_NOP  = 3'b000;
  localparam logic [4:0] NOP_REG_ADDR = 5'b00000;

  // IF/ID boundary layout (LSB first): inst[31:0], pc[63:32].
  localparam int IFID_INST_LSB = 0;
  localparam int IFID_PC_LSB   = 32;
  localparam int IFID_W        = 64;

  // ID/EX boundary layout (LSB first).
  localparam int IDEX_DS_LSB     = 0;    // delayslot, 1 bit
  localparam int IDEX_LINK_LSB   = 1;    // link address, 32 bits
  localparam int IDEX_WREG_LSB   = 33;   // write-enable, 1 bit
  localparam int IDEX_WD_LSB     = 34;   // destination register, 5 bits
  localparam int IDEX_REG2_LSB   = 39;   // operand 2, 32 bits
  localparam int IDEX_REG1_LSB   = 71;   // operand 1, 32 bits
  localparam int IDEX_ALUSEL_LSB = 103;  // alusel, 3 bits
  localparam int IDEX_ALUOP_LSB  = 106;  // aluop, 8 bits
  localparam int IDEX_W          = 114;

  // Bubble payload for the ID/EX boundary, assembled from the NOP fields.
  function automatic logic [IDEX_W-1:0] idex_nop();
    logic [IDEX_W-1:0] p;
    p = '0;
    p[IDEX_ALUOP_LSB  +: 8] = EXE_NOP_OP;
    p[IDEX_ALUSEL_LSB +: 3] = EXE_RES_NOP;
    p[IDEX_WD_LSB     +: 5] = NOP_REG_ADDR;
    return p;
  endfunction

endpackage

// File: rtl/pipe_stage_reg_sat.sv
// Saturating up-counter with synchronous clear; clear beats increment.
// Latency: count visible one cycle after inc/clr. No backpressure.
// Ports: clk, rst (async active-low), inc, clr -> cnt (CNT_W bits, stops at all-ones).
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic inter-stage pipeline register with load/bubble/hold/flush control.
// Latency: 1 cycle up_* -> down_*. Backpressure via global stall vector: HOLD
// freezes the slot, BUBBLE inserts a NOP. Optional perf counters under the
// PIPE_STAGE_PERF_CNT_EN macro (bubble_cnt/flush_cnt read 0 when undefined).
// Ports: clk, rst (async active-low), stall, flush, up_payload/up_valid/next_ds_i in;
// down_payload/down_valid/ds_fb_o, stall_err, hold_run, bubble_cnt, flush_cnt out.
module pipe_stage_reg
  import pipe_stage_reg_pkg::*;
#(
  parameter int                   PAYLOAD_W   = IDEX_W,
  parameter logic [PAYLOAD_W-1:0] NOP_PAYLOAD = {PAYLOAD_W{1'b0}},
  parameter int                   STALL_W     = STALL_W_DEF,
  parameter int                   STAGE_IDX   = 2,   // must be 0..STALL_W-2
  parameter int                   CNT_W       = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [STALL_W-1:0]   stall,
  input  logic                 flush,
  input  logic [PAYLOAD_W-1:0] up_payload,
  input  logic                 up_valid,
  input  logic                 next_ds_i,
  output logic [PAYLOAD_W-1:0] down_payload,
  output logic                 down_valid,
  output logic                 ds_fb_o,
  output logic                 stall_err,
  output logic [CNT_W-1:0]     hold_run,
  output logic [CNT_W-1:0]     bubble_cnt,
  output logic [CNT_W-1:0]     flush_cnt
);

  // s: our upstream stage is stopped; d: the downstream stage is stopped.
  logic s;
  logic d;
  assign s = (stall[STAGE_IDX]   == STOP);
  assign d = (stall[STAGE_IDX+1] == STOP);

  // Only two bits of the stall vector matter for this instance.
  logic unused_stall;
  assign unused_stall = ^stall;

  logic [PAYLOAD_W-1:0] payload_q, payload_d;
  logic                 valid_q,   valid_d;
  logic                 ds_q,      ds_d;
  logic                 err_q,     err_d;

  // Stage events, already qualified by flush priority.
  logic ev_bubble;
  logic ev_hold;     // HOLD or the illegal s=0,d=1 pattern
  assign ev_bubble = !flush && s && !d;
  assign ev_hold   = !flush && d;

  always_comb begin
    payload_d = payload_q;
    valid_d   = valid_q;
    ds_d      = ds_q;
    err_d     = 1'b0;
    if (flush) begin
      payload_d = NOP_PAYLOAD;
      valid_d   = 1'b0;
      ds_d      = 1'b0;
    end else begin
      unique case ({s, d})
        2'b10: begin  // BUBBLE: drop the slot, keep delay-slot feedback
          payload_d = NOP_PAYLOAD;
          valid_d   = 1'b0;
        end
        2'b11: begin  // HOLD
        end
        2'b00: begin  // LOAD
          payload_d = up_payload;
          valid_d   = up_valid;
          ds_d      = next_ds_i;
        end
        default: begin  // downstream stopped while upstream runs: hold and flag
          err_d = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      payload_q <= NOP_PAYLOAD;
      valid_q   <= 1'b0;
      ds_q      <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      payload_q <= payload_d;
      valid_q   <= valid_d;
      ds_q      <= ds_d;
      err_q     <= err_d;
    end
  end

  assign down_payload = payload_q;
  assign down_valid   = valid_q;
  assign ds_fb_o      = ds_q;
  assign stall_err    = err_q;

  // Run length of consecutive held cycles; any non-hold edge restarts it.
  sat_counter #(.CNT_W(CNT_W)) u_hold_run (
    .clk (clk),
    .rst (rst),
    .inc (ev_hold),
    .clr (!ev_hold),
    .cnt (hold_run)
  );

`ifdef PIPE_STAGE_PERF_CNT_EN
  sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
    .clk (clk),
    .rst (rst),
    .inc (ev_bubble),
    .clr (1'b0),
    .cnt (bubble_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk (clk),
    .rst (rst),
    .inc (flush),
    .clr (1'b0),
    .cnt (flush_cnt)
  );
`else
  logic unused_bubble;
  assign unused_bubble = ev_bubble;
  assign bubble_cnt    = '0;
  assign flush_cnt     = '0;
`endif

endmodule
